// File: rtl/pipeline_step_controller.sv
// Board front-end: synchronised, debounced buttons drive a halt/run/step/burst/flush pipeline control FSM.
// Latency: button pulse DEBOUNCE_CYCLES+1 edges after raw rise, FSM outputs one edge later; no backpressure.
module pipeline_step_controller #(
    parameter int N_SW            = 4,
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FLUSH_CYCLES    = 3,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  switches,
    input  logic [N_BTN-1:0] buttons,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             run_led,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_CYCLES);
    localparam int BC_W = N_SW;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    logic [N_BTN-1:0]           btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [N_SW-1:0]            sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [N_BTN-1:0]           db_lvl_q, db_lvl_d;
    logic [N_BTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [N_BTN-1:0]           btn_pulse_q, btn_pulse_d;

    state_t           state_q, state_d;
    logic             pipe_en_q, pipe_en_d;
    logic             pipe_flush_q, pipe_flush_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic step_p, run_p, flush_p;

    always_comb begin
        btn_s1_d = buttons;
        btn_s2_d = btn_s1_q;
        sw_s1_d  = switches;
        sw_s2_d  = sw_s1_q;
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_lvl_d    = db_lvl_q;
        db_cnt_d    = '0;
        btn_pulse_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_s2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i]    = btn_s2_q[i];
                    btn_pulse_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign step_p  = btn_pulse_q[0];
    assign run_p   = btn_pulse_q[1];
    assign flush_p = btn_pulse_q[2];

    always_comb begin
        state_d       = state_q;
        pipe_en_d     = 1'b0;
        pipe_flush_d  = 1'b0;
        burst_cnt_d   = burst_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        cycle_count_d = cycle_count_q + CNT_W'(pipe_en_q);

        if (state_q != ST_FLUSH && flush_p) begin
            state_d       = ST_FLUSH;
            flush_cnt_d   = FL_INIT;
            pipe_flush_d  = 1'b1;
            cycle_count_d = '0;
        end else begin
            unique case (state_q)
                ST_HALT: begin
                    if (run_p) begin
                        state_d   = ST_RUN;
                        pipe_en_d = 1'b1;
                    end else if (step_p) begin
                        pipe_en_d = 1'b1;
                        if (sw_s2_q[N_SW-1]) begin
                            state_d     = ST_BURST;
                            burst_cnt_d = {1'b0, sw_s2_q[N_SW-2:0]} + BC_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (run_p) begin
                        state_d = ST_HALT;
                    end else begin
                        pipe_en_d = 1'b1;
                    end
                end
                ST_BURST: begin
                    // The current cycle is the last enabled one when the count reaches 1.
                    if (run_p || burst_cnt_q == BC_W'(1)) begin
                        state_d = ST_HALT;
                    end else begin
                        burst_cnt_d = burst_cnt_q - BC_W'(1);
                        pipe_en_d   = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FL_W'(1)) begin
                        state_d = ST_HALT;
                    end else begin
                        flush_cnt_d  = flush_cnt_q - FL_W'(1);
                        pipe_flush_d = 1'b1;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            db_lvl_q      <= '0;
            db_cnt_q      <= '0;
            btn_pulse_q   <= '0;
            state_q       <= ST_HALT;
            pipe_en_q     <= 1'b0;
            pipe_flush_q  <= 1'b0;
            burst_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            db_lvl_q      <= db_lvl_d;
            db_cnt_q      <= db_cnt_d;
            btn_pulse_q   <= btn_pulse_d;
            state_q       <= state_d;
            pipe_en_q     <= pipe_en_d;
            pipe_flush_q  <= pipe_flush_d;
            burst_cnt_q   <= burst_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign pipe_en     = pipe_en_q;
    assign pipe_flush  = pipe_flush_q;
    assign run_led     = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign btn_pulse   = btn_pulse_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Directed bench for pipeline_step_controller with a sliding-window/schedule reference model.
module tb_pipeline_step_controller;

    localparam int D = 4;
    localparam int F = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  switches;
    logic [2:0]  buttons;
    logic        pipe_en;
    logic        pipe_flush;
    logic        run_led;
    logic [1:0]  state;
    logic [15:0] cycle_count;
    logic [2:0]  btn_pulse;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    pipeline_step_controller #(
        .N_SW(4), .N_BTN(3), .DEBOUNCE_CYCLES(D), .FLUSH_CYCLES(F), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches), .buttons(buttons),
        .pipe_en(pipe_en), .pipe_flush(pipe_flush), .run_led(run_led),
        .state(state), .cycle_count(cycle_count), .btn_pulse(btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: raw samples history, sliding debounce window, and remaining-cycle schedules.
    logic [2:0]  btn_hist[$];
    logic [3:0]  sw_hist[$];
    logic [2:0]  seen_win[$];
    logic [2:0]  m_level, m_pulse;
    logic [15:0] m_count;
    bit          m_run, m_single, m_en, m_fl;
    int          burst_left, flush_left;

    initial begin
        logic [2:0] seen, p;
        logic [3:0] swv;
        bit all_diff;
        m_level = '0; m_pulse = '0; m_count = '0; m_run = 0; m_single = 0;
        m_en = 0; m_fl = 0; burst_left = 0; flush_left = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                btn_hist.delete(); sw_hist.delete(); seen_win.delete();
                m_level = '0; m_pulse = '0; m_count = '0; m_run = 0; m_single = 0;
                m_en = 0; m_fl = 0; burst_left = 0; flush_left = 0;
            end else begin
                btn_hist.push_back(buttons);
                sw_hist.push_back(switches);
                if (btn_hist.size() > 3) void'(btn_hist.pop_front());
                if (sw_hist.size() > 3) void'(sw_hist.pop_front());
                seen = (btn_hist.size() == 3) ? btn_hist[0] : 3'b000;
                swv  = (sw_hist.size() == 3) ? sw_hist[0] : 4'b0000;
                p = m_pulse;
                if (m_en) m_count = m_count + 16'd1;
                m_single = 0;
                if (flush_left > 0) begin
                    flush_left--;
                end else if (p[2]) begin
                    flush_left = F; m_run = 0; burst_left = 0; m_count = '0;
                end else if (p[1] && (m_run || burst_left > 0)) begin
                    m_run = 0; burst_left = 0;
                end else if (p[1]) begin
                    m_run = 1;
                end else if (burst_left > 0) begin
                    burst_left--;
                end else if (p[0] && !m_run) begin
                    if (swv[3]) burst_left = int'(swv[2:0]) + 1;
                    else m_single = 1;
                end
                m_en = m_run || m_single || (burst_left > 0);
                m_fl = (flush_left > 0);
                seen_win.push_back(seen);
                if (seen_win.size() > D) void'(seen_win.pop_front());
                m_pulse = '0;
                for (int i = 0; i < 3; i++) begin
                    if (seen_win.size() == D) begin
                        all_diff = 1;
                        for (int k = 0; k < D; k++)
                            if (seen_win[k][i] == m_level[i]) all_diff = 0;
                        if (all_diff) begin
                            m_level[i] = ~m_level[i];
                            m_pulse[i] = m_level[i];
                        end
                    end
                end
            end
        end
    end

    initial begin
        int ms;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ms = (flush_left > 0) ? 3 : (m_run ? 1 : ((burst_left > 0) ? 2 : 0));
                check("pipe_en", pipe_en, m_en);
                check("pipe_flush", pipe_flush, m_fl);
                check("state", state, ms);
                check("run_led", run_led, (ms == 1 || ms == 2) ? 1 : 0);
                check("cycle_count", cycle_count, m_count);
                check("btn_pulse", btn_pulse, m_pulse);
                check("en_flush_exclusive", pipe_en & pipe_flush, 0);
            end
        end
    end

    initial begin
        int pc, pk, ec, fl, both, first_cnt, saw;
        bit found;
        rst_n = 1'b0; buttons = '0; switches = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pipe_en", pipe_en, 0);
        check("rst_pipe_flush", pipe_flush, 0);
        check("rst_state", state, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_btn_pulse", btn_pulse, 0);
        check("rst_run_led", run_led, 0);
        @(posedge clk); #2 rst_n = 1'b1; chk_en = 1;
        repeat (3) @(posedge clk);
        #2;

        // single step: pulse after the 5th edge counting the first sampling edge as 0
        buttons = 3'b001; pc = 0; pk = -1; ec = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (btn_pulse[0]) begin pc++; pk = k; end
            if (pipe_en) ec++;
            if (k == 9) buttons = 3'b000;
        end
        check("step_pulse_count", pc, 1);
        check("step_pulse_edge", pk, 5);
        check("step_en_cycles", ec, 1);
        check("step_cycle_count", cycle_count, 1);
        repeat (8) @(posedge clk);
        #1;

        // 3-cycle glitch on run button
        buttons = 3'b010; pc = 0; ec = 0; saw = 0;
        repeat (3) @(posedge clk);
        #1 buttons = 3'b000;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (btn_pulse != 0) pc++;
            if (pipe_en) ec++;
            if (state != 0) saw++;
        end
        check("glitch_pulses", pc, 0);
        check("glitch_en", ec, 0);
        check("glitch_state_moves", saw, 0);

        // burst of 3
        switches = 4'b1010;
        repeat (4) @(posedge clk);
        #1 buttons = 3'b001; ec = 0; saw = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (pipe_en) ec++;
            if (state == 2) saw = 1;
            if (k == 9) buttons = 3'b000;
        end
        check("burst_en_cycles", ec, 3);
        check("burst_seen", saw, 1);
        check("burst_end_state", state, 0);
        check("burst_cycle_count", cycle_count, 4);

        // run press, then continuous enable
        buttons = 3'b010;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == 9) buttons = 3'b000;
        end
        check("run_state", state, 1);
        check("run_led_on", run_led, 1);
        ec = 0;
        repeat (10) begin @(posedge clk); #1; if (pipe_en) ec++; end
        check("run_en_continuous", ec, 10);

        // second run press halts on the edge after its pulse
        buttons = 3'b010; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (btn_pulse[1]) found = 1;
        end
        check("run2_pulse_found", found, 1);
        @(posedge clk); #1;
        check("run2_halt", state, 0);
        check("run2_en_off", pipe_en, 0);
        buttons = 3'b000;
        repeat (10) @(posedge clk);
        #1;

        // RUN, then run+flush together: flush wins
        buttons = 3'b010;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == 9) buttons = 3'b000;
        end
        repeat (3) @(posedge clk);
        #1;
        check("pre_flush_state", state, 1);
        buttons = 3'b110; fl = 0; both = 0; first_cnt = -1; saw = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pipe_flush) begin
                fl++;
                if (first_cnt < 0) first_cnt = cycle_count;
                if (pipe_en) both++;
            end
            if (state == 3) saw = 1;
            if (k == 9) buttons = 3'b000;
        end
        check("flush_cycles", fl, 3);
        check("flush_en_overlap", both, 0);
        check("flush_count_cleared", first_cnt, 0);
        check("flush_state_seen", saw, 1);
        check("flush_end_state", state, 0);
        check("flush_end_en", pipe_en, 0);
        repeat (6) @(posedge clk);
        #1;

        // async reset in the middle of an 8-cycle burst
        switches = 4'b1111;
        repeat (4) @(posedge clk);
        #1 buttons = 3'b001; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (state == 2) found = 1;
        end
        check("mid_burst_reached", found, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_pipe_en", pipe_en, 0);
        check("arst_state", state, 0);
        check("arst_cycle_count", cycle_count, 0);
        check("arst_run_led", run_led, 0);
        check("arst_pipe_flush", pipe_flush, 0);
        buttons = 3'b000; switches = 4'b0000;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 buttons = 3'b001; ec = 0; pc = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pipe_en) ec++;
            if (btn_pulse[0]) pc++;
            if (k == 9) buttons = 3'b000;
        end
        check("post_rst_pulses", pc, 1);
        check("post_rst_en", ec, 1);
        check("post_rst_count", cycle_count, 1);
        check("post_rst_state", state, 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
